// File: rtl/add4_share_arbiter_if.sv
// Requester-side bundle for the shared 4-input adder: the request handshakes of
// the W unit (r0) and the T1 unit (r1), plus the tagged result bus they share.
interface add4_share_arbiter_if;
    logic         r0_valid;
    logic         r0_ready;
    logic         r0_mode64;
    logic [255:0] r0_ops;
    logic         r0_res_valid;
    logic         r1_valid;
    logic         r1_ready;
    logic         r1_mode64;
    logic [255:0] r1_ops;
    logic         r1_res_valid;
    logic [63:0]  res_data;

    modport master (
        output r0_valid, r0_mode64, r0_ops,
        output r1_valid, r1_mode64, r1_ops,
        input  r0_ready, r0_res_valid,
        input  r1_ready, r1_res_valid,
        input  res_data
    );

    modport slave (
        input  r0_valid, r0_mode64, r0_ops,
        input  r1_valid, r1_mode64, r1_ops,
        output r0_ready, r0_res_valid,
        output r1_ready, r1_res_valid,
        output res_data
    );
endinterface

// File: rtl/add4_share_arbiter.sv
// Round-robin arbiter sharing one pipelined 4-input adder between the W unit (r0)
// and the T1 unit (r1); the adder is drained before any change of word size.
module add4_share_arbiter #(
    parameter int ADD_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    add4_share_arbiter_if.slave req,
    output logic                add_mode64,
    output logic [63:0]         add_a,
    output logic [63:0]         add_b,
    output logic [63:0]         add_c,
    output logic [63:0]         add_d,
    input  logic [63:0]         add_sum,
    output logic                busy
);
    localparam int TAG_DEPTH = 1 + ADD_LATENCY;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic                 cur_mode_r;
    logic                 last_id_r;
    logic                 blocked_id_r;
    logic                 blocked_id_next_s;
    logic [TAG_DEPTH-1:0] tag_valid_r;
    logic [TAG_DEPTH-1:0] tag_id_r;
    logic [TAG_DEPTH-1:0] tag_valid_next_s;
    logic [TAG_DEPTH-1:0] tag_id_next_s;
    logic                 busy_r;
    logic                 mis0_s;
    logic                 mis1_s;
    logic                 rr_pick_s;
    logic                 gnt0_s;
    logic                 gnt1_s;
    logic                 gnt_any_s;
    logic                 gnt_mode_s;
    logic [255:0]         gnt_ops_s;

    // Next-state and grant decision for the run/drain sequencer
    always_comb begin
        state_next_s      = state_r;
        blocked_id_next_s = blocked_id_r;
        gnt0_s            = 1'b0;
        gnt1_s            = 1'b0;
        // rr_pick_s is the id that wins a tie: whoever was not granted last
        rr_pick_s         = ~last_id_r;
        mis0_s            = req.r0_valid & (req.r0_mode64 != cur_mode_r);
        mis1_s            = req.r1_valid & (req.r1_mode64 != cur_mode_r);
        case (state_r)
            ST_RUN: begin
                if (busy_r && (mis0_s || mis1_s)) begin
                    state_next_s = ST_DRAIN;
                    if (mis0_s && mis1_s) begin
                        blocked_id_next_s = rr_pick_s;
                    end else begin
                        blocked_id_next_s = mis1_s;
                    end
                end else if (req.r0_valid && req.r1_valid) begin
                    // No mismatch is pending here, so every valid requester is eligible
                    gnt0_s = ~rr_pick_s;
                    gnt1_s = rr_pick_s;
                end else begin
                    gnt0_s = req.r0_valid;
                    gnt1_s = req.r1_valid;
                end
            end
            ST_DRAIN: begin
                if (busy_r) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                    if (req.r0_valid && req.r1_valid) begin
                        gnt0_s = ~blocked_id_r;
                        gnt1_s = blocked_id_r;
                    end else begin
                        gnt0_s = req.r0_valid;
                        gnt1_s = req.r1_valid;
                    end
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Issue-stage operand steering and next tag-pipeline contents
    always_comb begin
        gnt_any_s = (gnt0_s | gnt1_s) & ~rst;
        if (gnt1_s) begin
            gnt_mode_s = req.r1_mode64;
            gnt_ops_s  = req.r1_ops;
        end else begin
            gnt_mode_s = req.r0_mode64;
            gnt_ops_s  = req.r0_ops;
        end
        tag_valid_next_s = {tag_valid_r[TAG_DEPTH-2:0], gnt_any_s};
        tag_id_next_s    = {tag_id_r[TAG_DEPTH-2:0], gnt1_s};
    end

    assign req.r0_ready     = gnt0_s & ~rst;
    assign req.r1_ready     = gnt1_s & ~rst;
    assign req.r0_res_valid = tag_valid_r[TAG_DEPTH-1] & ~tag_id_r[TAG_DEPTH-1];
    assign req.r1_res_valid = tag_valid_r[TAG_DEPTH-1] & tag_id_r[TAG_DEPTH-1];
    assign req.res_data     = add_sum;
    assign busy             = busy_r;

    // Sequencer state, round-robin pointer, issue registers and tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_RUN;
            cur_mode_r   <= 1'b0;
            last_id_r    <= 1'b1;
            blocked_id_r <= 1'b0;
            tag_valid_r  <= {TAG_DEPTH{1'b0}};
            tag_id_r     <= {TAG_DEPTH{1'b0}};
            busy_r       <= 1'b0;
            add_mode64   <= 1'b0;
            add_a        <= 64'd0;
            add_b        <= 64'd0;
            add_c        <= 64'd0;
            add_d        <= 64'd0;
        end else begin
            state_r      <= state_next_s;
            blocked_id_r <= blocked_id_next_s;
            tag_valid_r  <= tag_valid_next_s;
            tag_id_r     <= tag_id_next_s;
            // busy mirrors the OR of the tag valids that are about to be held
            busy_r       <= |tag_valid_next_s;
            if (gnt_any_s) begin
                cur_mode_r <= gnt_mode_s;
                last_id_r  <= gnt1_s;
                add_mode64 <= gnt_mode_s;
                add_a      <= gnt_ops_s[255:192];
                add_b      <= gnt_ops_s[191:128];
                add_c      <= gnt_ops_s[127:64];
                add_d      <= gnt_ops_s[63:0];
            end else begin
                cur_mode_r <= cur_mode_r;
                last_id_r  <= last_id_r;
                add_mode64 <= add_mode64;
                add_a      <= add_a;
                add_b      <= add_b;
                add_c      <= add_c;
                add_d      <= add_d;
            end
        end
    end
endmodule

// File: tb/tb_add4_share_arbiter.sv
// Randomised bench for add4_share_arbiter: a rule-level arbitration model and an
// expected-result queue checked by a negedge monitor against a pipelined adder model.
module tb_add4_share_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        add_mode64;
    logic [63:0] add_a, add_b, add_c, add_d, add_sum;
    logic        busy;

    always #5 clk = ~clk;

    add4_share_arbiter_if bus ();

    add4_share_arbiter #(.ADD_LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (bus),
        .add_mode64(add_mode64),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .add_d     (add_d),
        .add_sum   (add_sum),
        .busy      (busy)
    );

    // Behavioural adder: LAT register stages from add_* to add_sum, never reset
    logic [63:0] add_pipe [LAT];
    always @(posedge clk) begin
        logic [63:0] s;
        s = add_a + add_b + add_c + add_d;
        if (!add_mode64) s[63:32] = 32'd0;
        add_pipe[0] <= s;
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_sum = add_pipe[LAT-1];

    typedef struct {bit mode; logic [255:0] ops; int gap;} req_t;
    typedef struct {bit id; logic [63:0] sum; int due;} exp_t;

    req_t rq0[$], rq1[$];
    req_t cur0, cur1;
    bit   arm0, arm1;
    int   wait0, wait1;
    exp_t expq[$];
    int   total = 0, bad = 0;
    int   cyc = 0;

    // reference-model state
    int          lg = -1000;
    bit          m_cur, m_last, m_drain, m_blocked, mvalid;
    bit          g0_m, g1_m;
    logic [63:0] e_a, e_b, e_c, e_d;
    bit          e_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic fail(input string name, input int act, input int want);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    endtask

    function automatic logic [63:0] ref_sum(input bit m, input logic [255:0] ops);
        logic [65:0] full;
        logic [33:0] low;
        full = 66'(ops[255:192]) + 66'(ops[191:128]) + 66'(ops[127:64]) + 66'(ops[63:0]);
        low  = 34'(ops[223:192]) + 34'(ops[159:128]) + 34'(ops[95:64]) + 34'(ops[31:0]);
        return m ? full[63:0] : {32'd0, low[31:0]};
    endfunction

    // Monitor + model: check outputs, predict grants, then advance the model one cycle
    always @(negedge clk) begin : mon
        bit   busy_m, v0, v1, mis0, mis1, pref, g0, g1, gid, gm;
        logic [255:0] gops;
        exp_t e;
        busy_m = (cyc - lg >= 1) && (cyc - lg <= LAT + 1);
        if (mvalid) begin
            chk("busy", busy, busy_m);
            chk("add_a", add_a, e_a);
            chk("add_b", add_b, e_b);
            chk("add_c", add_c, e_c);
            chk("add_d", add_d, e_d);
            chk("add_mode64", add_mode64, e_m);
            if (bus.r0_res_valid || bus.r1_res_valid) begin
                if (expq.size() == 0) begin
                    fail("spurious res_valid", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("res owner r1", bus.r1_res_valid, e.id);
                    chk("res owner r0", bus.r0_res_valid, !e.id);
                    chk("res_data", bus.res_data, e.sum);
                    chk("res cycle", cyc, e.due);
                end
            end else if (expq.size() > 0 && expq[0].due <= cyc) begin
                e = expq.pop_front();
                fail("missing result due at cycle", cyc, e.due);
            end
        end
        v0 = bus.r0_valid;
        v1 = bus.r1_valid;
        g0 = 1'b0;
        g1 = 1'b0;
        pref = ~m_last;
        if (rst) begin
            g0 = 1'b0;
        end else if (!m_drain) begin
            mis0 = v0 && (bus.r0_mode64 != m_cur);
            mis1 = v1 && (bus.r1_mode64 != m_cur);
            if (busy_m && (mis0 || mis1)) begin
                m_drain   = 1'b1;
                m_blocked = (mis0 && mis1) ? pref : mis1;
            end else if (v0 && v1) begin
                g0 = !pref;
                g1 = pref;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end else if (!busy_m) begin
            m_drain = 1'b0;
            if (v0 && v1) begin
                g0 = !m_blocked;
                g1 = m_blocked;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        chk("r0_ready", bus.r0_ready, g0);
        chk("r1_ready", bus.r1_ready, g1);
        if (rst) begin
            m_cur = 1'b0; m_last = 1'b1; m_drain = 1'b0; lg = -1000;
            expq.delete();
            e_a = 64'd0; e_b = 64'd0; e_c = 64'd0; e_d = 64'd0; e_m = 1'b0;
            mvalid = 1'b1;
        end else if (g0 || g1) begin
            gid  = g1;
            gm   = gid ? bus.r1_mode64 : bus.r0_mode64;
            gops = gid ? bus.r1_ops : bus.r0_ops;
            m_cur = gm; m_last = gid; lg = cyc;
            e_a = gops[255:192]; e_b = gops[191:128]; e_c = gops[127:64]; e_d = gops[63:0]; e_m = gm;
            expq.push_back('{id: gid, sum: ref_sum(gm, gops), due: cyc + 1 + LAT});
        end
        g0_m = g0;
        g1_m = g1;
        cyc++;
    end

    // Requester driver: holds each request until the model sees it granted
    initial begin
        bus.r0_valid = 1'b0; bus.r0_mode64 = 1'b0; bus.r0_ops = 256'd0;
        bus.r1_valid = 1'b0; bus.r1_mode64 = 1'b0; bus.r1_ops = 256'd0;
        arm0 = 1'b0; arm1 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.r0_valid && g0_m) bus.r0_valid = 1'b0;
            if (!bus.r0_valid) begin
                if (!arm0 && rq0.size() > 0) begin cur0 = rq0.pop_front(); arm0 = 1'b1; wait0 = cur0.gap; end
                if (arm0) begin
                    if (wait0 > 0) wait0--;
                    else begin
                        bus.r0_valid = 1'b1; bus.r0_mode64 = cur0.mode; bus.r0_ops = cur0.ops; arm0 = 1'b0;
                    end
                end
            end
            if (bus.r1_valid && g1_m) bus.r1_valid = 1'b0;
            if (!bus.r1_valid) begin
                if (!arm1 && rq1.size() > 0) begin cur1 = rq1.pop_front(); arm1 = 1'b1; wait1 = cur1.gap; end
                if (arm1) begin
                    if (wait1 > 0) wait1--;
                    else begin
                        bus.r1_valid = 1'b1; bus.r1_mode64 = cur1.mode; bus.r1_ops = cur1.ops; arm1 = 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [255:0] rand_ops();
        logic [255:0] ones;
        ones = '1;
        if ($urandom_range(0, 15) == 0) return ones;
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || arm0 || arm1 || bus.r0_valid || bus.r1_valid
                || expq.size() > 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) fail("idle wait timeout", n, budget);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bit rm0, rm1;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single op: 1+2+3+4 in 64-bit mode
        rq0.push_back('{mode: 1'b1, ops: {64'd1, 64'd2, 64'd3, 64'd4}, gap: 0});
        wait_idle(100);

        // overflow in both word sizes (upper words must be ignored in 32-bit mode)
        rq0.push_back('{mode: 1'b1, ops: {4{64'hFFFF_FFFF_FFFF_FFFF}}, gap: 0});
        wait_idle(100);
        rq1.push_back('{mode: 1'b0, ops: {4{64'h1234_5678_FFFF_FFFF}}, gap: 0});
        wait_idle(100);

        // contention, same mode: grants must alternate
        for (int i = 0; i < 4; i++) begin
            rq0.push_back('{mode: 1'b1, ops: rand_ops(), gap: 0});
            rq1.push_back('{mode: 1'b1, ops: rand_ops(), gap: 0});
        end
        wait_idle(200);

        // mode change under load: r1 asks for 32-bit while r0 streams 64-bit
        for (int i = 0; i < 6; i++) rq0.push_back('{mode: 1'b1, ops: rand_ops(), gap: 0});
        rq1.push_back('{mode: 1'b0, ops: rand_ops(), gap: 2});
        wait_idle(200);

        // reset one cycle after a grant: its result must never appear
        rq0.push_back('{mode: 1'b1, ops: rand_ops(), gap: 0});
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!g0_m && n < 50);
        if (!g0_m) fail("grant before reset timeout", n, 50);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle(100);
        rq1.push_back('{mode: 1'b0, ops: rand_ops(), gap: 0});
        wait_idle(100);

        // random traffic with independently drifting modes
        rm0 = 1'b1;
        rm1 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rm0 = ~rm0;
            if ($urandom_range(0, 7) == 0) rm1 = ~rm1;
            rq0.push_back('{mode: rm0, ops: rand_ops(),
                            gap: ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0});
            rq1.push_back('{mode: rm1, ops: rand_ops(),
                            gap: ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0});
        end
        wait_idle(20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/add4_share_arbiter.md
# add4_share_arbiter

Round-robin arbiter and sequencer that shares one pipelined 4-input modular adder between two requesters: requester 0 is the message-schedule W unit and requester 1 is the compression-round T1 unit. It registers the granted operands into the adder and tracks every in-flight operation with a tag pipeline so that each result returns to its owner. It also drains the adder before any change of `mode64`, so that 32-bit (SHA-256) and 64-bit (SHA-512) operations never share the pipeline.

## Interface
- `ADD_LATENCY`, 2: register stages inside the adder, from its operand inputs to `add_sum`.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `r0_valid` in 1: requester 0 has an operation pending.
- `r0_ready` out 1: requester 0 is granted this cycle.
- `r0_mode64` in 1: requester 0 mode; 1 = 64-bit, 0 = 32-bit.
- `r0_ops` in 256: requester 0 operands {A,B,C,D}, with A in bits [255:192].
- `r0_res_valid` out 1: a requester 0 result is on `res_data`.
- `r1_valid`, `r1_ready`, `r1_mode64`, `r1_ops`, `r1_res_valid`: same as requester 0, for requester 1.
- `res_data` out 64: shared result bus, driven combinationally from `add_sum`.
- `add_mode64` out 1: registered mode sent to the adder.
- `add_a`, `add_b`, `add_c`, `add_d` out 64 each: registered operands sent to the adder.
- `add_sum` in 64: adder result.
- `busy` out 1: at least one operation is in flight.

## Operation
- **Handshake.**
  - A transfer occurs when `rX_valid & rX_ready`.
  - `rX_ready` is combinational from the valid inputs, the state and the pipeline contents.
  - A requester holds `valid`, `ops` and `mode64` stable until it is granted.
  - There is no result backpressure: the owner must accept `rX_res_valid` in the cycle it is asserted.
- **Grant.** At most one grant per cycle.
  - Eligible means `rX_valid` and either the pipeline is empty, or state = RUN and `rX_mode64 == cur_mode`.
  - When both requesters are eligible, the one not granted last wins.
  - Exception: on the cycle DRAIN exits, the recorded `blocked_id` wins.
- **Mode register.** On every grant, `cur_mode <= rX_mode64`.
- **State machine** (2 states):
  - RUN → DRAIN when, in RUN, some `rX_valid` has `rX_mode64 != cur_mode` and the pipeline is not empty. Record `blocked_id` = that X; if both mismatch, record the round-robin winner. In this same cycle no grant is made, even to a matching requester.
  - In DRAIN, no grants are made while the pipeline is non-empty.
  - DRAIN → RUN on the cycle the pipeline becomes empty. A grant is allowed in that cycle with `blocked_id` priority.
- **Issue stage.** On a grant, register `ops` and `mode64` into `add_*`. Without a grant, `add_*` keep their previous values. The adder output is ignored unless tagged.
- **Tag pipeline.**
  - Shift register of depth `1 + ADD_LATENCY`; each entry holds {valid, id}.
  - Grant inserts {1, X}; otherwise {0, –} is inserted.
  - The tail entry drives `r0_res_valid` / `r1_res_valid`.
- **Status.** `busy` is the OR of all tag valids. "Pipeline empty" means `busy == 0`.
- **Arithmetic.** The sum is modulo 2^64 when `mode64` = 1, and modulo 2^32 in the low word when 0 (upper word 0). This arithmetic is the adder's; this block never modifies data.

## Timing
- **Reset values.**
  - `rX_ready` = 0 during reset.
  - `rX_res_valid` = 0, `busy` = 0.
  - `add_a` through `add_d` = 0, `add_mode64` = 0, `cur_mode` = 0.
  - State = RUN; last-grant pointer = 1, so requester 0 is preferred first.
- **Latency.** A grant in cycle t puts the operands on `add_*` in cycle t+1 and asserts `rX_res_valid` in cycle t+1+ADD_LATENCY. This is 3 cycles at the default.
- **Throughput.** One operation per cycle, for a single requester or alternating requesters.
- **Reset mid-operation.** All tags are cleared. No `res_valid` is produced for pre-reset operations, even though the adder still emits sums.
- **Mode change with an empty pipeline.** No DRAIN state and no bubble: the grant happens in the same cycle.
- **Drain cost.** Worst-case bubble for a mode change is 1 + ADD_LATENCY cycles.
- **Starvation.** `blocked_id` priority guarantees a mode-blocked requester is granted on DRAIN exit.

## Test plan
- **Reset and single op.** After reset, r0 issues mode64=1, ops {1,2,3,4} at t=5 → `r0_ready`=1 at t=5, `r0_res_valid`=1 and `res_data`=10 at t=8, `busy` low at t=8+1.
- **Contention.** r0 and r1 both valid for 4 cycles, ops differ per request → grants alternate r0,r1,r0,r1; each result is tagged to the correct requester in order, with 1 result per cycle.
- **Overflow.** mode64=1, all operands 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFC. mode64=0, low words 0xFFFF_FFFF → 0x0000_0000_FFFF_FFFC.
- **Mode change under load.** r0 streams mode64=1; r1 requests mode64=0 with 2 ops in flight → state goes to DRAIN, no grants until `busy`=0, then r1 is granted first even though r0 is still valid.
- **Reset mid-flight.** Grant at t, `rst` at t+1 → no `res_valid` at t+3; normal operation resumes after reset.
- **ADD_LATENCY=4 build.** Single op → `res_valid` at t+5; back-to-back ops are all returned.
